// File: rtl/sd_spi_pkg.sv
// sd_spi_pkg: shared definitions for the SD-card SPI master.
//   cmd_t      2-bit command code carried on the CPU-side bus
//   CMD_*      command codes (XFER, CS_LO, CS_HI, INIT)
//   state_t    controller FSM state encoding
package sd_spi_pkg;

    typedef logic [1:0] cmd_t;

    localparam cmd_t CMD_XFER  = 2'd0;   // exchange one byte
    localparam cmd_t CMD_CS_LO = 2'd1;   // assert card select
    localparam cmd_t CMD_CS_HI = 2'd2;   // deassert card select
    localparam cmd_t CMD_INIT  = 2'd3;   // CS high + 0xFF wake-up clocks

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,    // present bit 7 on MOSI before the first rising edge
        ST_SHIFT,   // 16 SCK half-periods per byte
        ST_NEXT,    // INIT byte boundary: count down, start the next byte
        ST_CS       // one-cycle CS_LO / CS_HI
    } state_t;

endpackage

// File: rtl/sd_spi_if.sv
// sd_spi_if: CPU-side command/status bus between the io port block and sd_spi.
//   start  one-cycle command strobe          (master -> slave)
//   cmd    command code, valid with start    (master -> slave)
//   din    byte to transmit, valid with start(master -> slave)
//   fast   speed select, valid with start    (master -> slave)
//   busy   command in progress               (slave -> master)
//   dout   last byte received by an XFER     (slave -> master)
interface sd_spi_if;
    import sd_spi_pkg::*;

    logic       start;
    cmd_t       cmd;
    logic [7:0] din;
    logic       fast;
    logic       busy;
    logic [7:0] dout;

    modport master (output start, cmd, din, fast, input busy, dout);
    modport slave  (input start, cmd, din, fast, output busy, dout);

endinterface

// File: rtl/sd_spi_div.sv
// sd_spi_div: loadable down-counter that times SCK half-periods.
//   clock, reset  system clock, synchronous active-high reset
//   clear         force the count to zero
//   load          load the count with reload (first half-period of a byte)
//   en            count while shifting
//   reload        half-period length minus one
//   tick          one-cycle pulse at the end of each half-period
module sd_spi_div #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] reload,
    output logic         tick
);

    logic [W-1:0] cnt;

    // A reload of zero ticks every enabled cycle, giving SCK = clock / 2.
    assign tick = en && (cnt == '0);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= reload;
        end else if (en) begin
            cnt <= (cnt == '0) ? reload : cnt - W'(1);
        end
    end

endmodule

// File: rtl/sd_spi.sv
// sd_spi: SPI mode-0 master for the SD card slot.
//   clock, reset  system clock, synchronous active-high reset
//   bus           CPU-side command bus (start/cmd/din/fast in, busy/dout out)
//   spi_sck       SD_CLK, idles low
//   spi_mosi      SD_CMD, idles high, MSB first, changes on SCK falling edge
//   spi_cs_n      SD_DATA[3], card select (active low)
//   spi_miso      SD_DATA[0], sampled on SCK rising edge
module sd_spi
    import sd_spi_pkg::*;
#(
    parameter int SLOW_DIV   = 31,
    parameter int FAST_DIV   = 1,
    parameter int INIT_BYTES = 10
) (
    input  logic    clock,
    input  logic    reset,
    sd_spi_if.slave bus,
    output logic    spi_sck,
    output logic    spi_mosi,
    output logic    spi_cs_n,
    input  logic    spi_miso
);

    localparam int DIV_W = 8;

    state_t           state_q, state_d;
    cmd_t             cmd_q;
    logic [DIV_W-1:0] div_val;     // H-1, fixed for the whole command
    logic [3:0]       bit_cnt;     // SCK edge index within a byte, 0..15
    logic [7:0]       byte_cnt;    // INIT bytes still to send after this one
    logic [7:0]       tx;
    logic [7:0]       rx;
    logic [7:0]       dout_q;
    logic             div_clear, div_load, div_en, tick;

    // Commands are only accepted in IDLE; a strobe while busy is dropped.
    logic accept;
    assign accept   = (state_q == ST_IDLE) && bus.start;
    assign bus.busy = (state_q != ST_IDLE);
    assign bus.dout = dout_q;

    logic last_edge;
    assign last_edge = tick && (bit_cnt == 4'd15);

    sd_spi_div #(.W(DIV_W)) u_div (
        .clock  (clock),
        .reset  (reset),
        .clear  (div_clear),
        .load   (div_load),
        .en     (div_en),
        .reload (div_val),
        .tick   (tick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block is given a default first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        div_clear = 1'b0;
        div_load  = 1'b0;
        div_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                div_clear = 1'b1;
                if (bus.start) begin
                    state_d = (bus.cmd == CMD_XFER || bus.cmd == CMD_INIT) ? ST_LOAD : ST_CS;
                end
            end
            ST_LOAD: begin
                div_load = 1'b1;
                state_d  = ST_SHIFT;
            end
            ST_SHIFT: begin
                div_en = 1'b1;
                if (last_edge) begin
                    state_d = (cmd_q == CMD_INIT) ? ST_NEXT : ST_IDLE;
                end
            end
            // The byte boundary doubles as the load cycle for the next INIT
            // byte, so a run of INIT_BYTES costs only one extra cycle per byte
            // over a single XFER plus a final cycle to close.
            ST_NEXT: begin
                if (byte_cnt != 8'd0) begin
                    div_load = 1'b1;
                    state_d  = ST_SHIFT;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_CS:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cmd_q    <= CMD_XFER;
            div_val  <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            tx       <= 8'hFF;
            rx       <= 8'h00;
            dout_q   <= 8'hFF;
            spi_sck  <= 1'b0;
            spi_mosi <= 1'b1;
            spi_cs_n <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        cmd_q   <= bus.cmd;
                        div_val <= bus.fast ? DIV_W'(FAST_DIV - 1) : DIV_W'(SLOW_DIV - 1);
                        bit_cnt <= '0;
                        case (bus.cmd)
                            CMD_XFER:  tx <= bus.din;
                            CMD_CS_LO: spi_cs_n <= 1'b0;
                            CMD_CS_HI: spi_cs_n <= 1'b1;
                            CMD_INIT: begin
                                tx       <= 8'hFF;
                                spi_cs_n <= 1'b1;
                                byte_cnt <= 8'(INIT_BYTES - 1);
                            end
                            default: ;
                        endcase
                    end
                end
                ST_LOAD: spi_mosi <= tx[7];
                ST_SHIFT: begin
                    if (tick) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (!bit_cnt[0]) begin
                            spi_sck <= 1'b1;
                            rx      <= {rx[6:0], spi_miso};
                        end else begin
                            spi_sck <= 1'b0;
                            // Ones shift in behind the data so MOSI is back
                            // at its idle level after the eighth falling edge.
                            tx       <= {tx[6:0], 1'b1};
                            spi_mosi <= (bit_cnt == 4'd15) ? 1'b1 : tx[6];
                            if (bit_cnt == 4'd15 && cmd_q == CMD_XFER) begin
                                dout_q <= rx;
                            end
                        end
                    end
                end
                ST_NEXT: begin
                    if (byte_cnt != 8'd0) begin
                        byte_cnt <= byte_cnt - 8'd1;
                        spi_mosi <= tx[7];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
